// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronizes the serial line, glitch-filters the start bit at mid-bit,
// samples each data/stop bit at its centre and flags framing errors and line breaks.
module uart_rx_frame #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Frame_Err,
   output logic       o_Break,
   output logic       o_Rx_Active
);

   localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
   localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

   localparam logic [2:0] s_IDLE      = 3'd0;
   localparam logic [2:0] s_START     = 3'd1;
   localparam logic [2:0] s_DATA      = 3'd2;
   localparam logic [2:0] s_STOP      = 3'd3;
   localparam logic [2:0] s_WAIT_HIGH = 3'd4;

   logic        r_Meta;
   logic        r_Rx;
   logic [2:0]  r_State;
   logic [15:0] r_Count;
   logic [2:0]  r_Index;
   logic [7:0]  r_Shift;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_Meta <= 1'b1;
         r_Rx   <= 1'b1;
      end else begin
         r_Meta <= i_Rx_Serial;
         r_Rx   <= r_Meta;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_State     <= s_IDLE;
         r_Count     <= '0;
         r_Index     <= '0;
         r_Shift     <= '0;
         o_Rx_DV     <= 1'b0;
         o_Rx_Byte   <= 8'h00;
         o_Frame_Err <= 1'b0;
         o_Break     <= 1'b0;
      end else begin
         o_Rx_DV     <= 1'b0;
         o_Frame_Err <= 1'b0;
         o_Break     <= 1'b0;
         case (r_State)
            s_IDLE: begin
               r_Count <= '0;
               r_Index <= '0;
               if (!r_Rx) r_State <= s_START;
            end
            s_START: begin
               if (r_Count == HALF_BIT) begin
                  r_Count <= '0;
                  // A start bit that has gone high by mid-bit is treated as noise
                  r_State <= r_Rx ? s_IDLE : s_DATA;
               end else begin
                  r_Count <= r_Count + 16'd1;
               end
            end
            s_DATA: begin
               if (r_Count == LAST_CLK) begin
                  r_Count          <= '0;
                  r_Shift[r_Index] <= r_Rx;
                  if (r_Index == 3'd7) begin
                     r_Index <= '0;
                     r_State <= s_STOP;
                  end else begin
                     r_Index <= r_Index + 3'd1;
                  end
               end else begin
                  r_Count <= r_Count + 16'd1;
               end
            end
            s_STOP: begin
               if (r_Count == LAST_CLK) begin
                  r_Count <= '0;
                  if (r_Rx) begin
                     o_Rx_Byte <= r_Shift;
                     o_Rx_DV   <= 1'b1;
                     r_State   <= s_IDLE;
                  end else begin
                     o_Frame_Err <= 1'b1;
                     o_Break     <= (r_Shift == 8'h00);
                     r_State     <= s_WAIT_HIGH;
                  end
               end else begin
                  r_Count <= r_Count + 16'd1;
               end
            end
            s_WAIT_HIGH: begin
               if (r_Rx) r_State <= s_IDLE;
            end
            default: r_State <= s_IDLE;
         endcase
      end
   end

   assign o_Rx_Active = (r_State == s_START) || (r_State == s_DATA) || (r_State == s_STOP);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: one instance at 4 clocks/bit, one at 16 clocks/bit.
module tb_uart_rx_frame;

   logic       i_Clock;
   logic       i_Reset;
   logic       rx4, rx16;
   logic       dv4, fe4, brk4, act4;
   logic [7:0] byte4;
   logic       dv16, fe16, brk16, act16;
   logic [7:0] byte16;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] dv4_byte[$];
   int         dv4_cyc[$];
   int         fe4_n = 0, brk4_n = 0, brk4_solo = 0;
   int         dv16_n = 0, fe16_n = 0, act16_n = 0;

   uart_rx_frame #(.CLKS_PER_BIT(4)) dut4 (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_Serial(rx4),
      .o_Rx_DV(dv4), .o_Rx_Byte(byte4), .o_Frame_Err(fe4), .o_Break(brk4),
      .o_Rx_Active(act4)
   );

   uart_rx_frame #(.CLKS_PER_BIT(16)) dut16 (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_Serial(rx16),
      .o_Rx_DV(dv16), .o_Rx_Byte(byte16), .o_Frame_Err(fe16), .o_Break(brk16),
      .o_Rx_Active(act16)
   );

   initial i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   always @(posedge i_Clock) cyc <= cyc + 1;

   always @(negedge i_Clock) begin
      if (dv4) begin
         dv4_byte.push_back(byte4);
         dv4_cyc.push_back(cyc);
      end
      if (fe4) fe4_n++;
      if (brk4) brk4_n++;
      if (brk4 && !fe4) brk4_solo++;
      if (dv16) dv16_n++;
      if (fe16 || brk16) fe16_n++;
      if (act16) act16_n++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_Clock);
   endtask

   // Drives one 8N1 frame on the CPB=4 line; e0 is the cycle at which IDLE sees the start bit
   task automatic send4(input logic [7:0] b, input logic stop, output int e0);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      e0 = cyc + 3;
      for (int i = 0; i < 10; i++) begin
         rx4 = bits[i];
         idle(4);
      end
      rx4 = 1'b1;
   endtask

   int e0, e1, e2, fe_base, brk_base;

   initial begin
      i_Reset = 1'b1;
      rx4     = 1'b1;
      rx16    = 1'b1;
      idle(3);
      check("reset_dv", 32'(dv4), 32'd0);
      check("reset_byte", 32'(byte4), 32'h00);
      check("reset_fe_brk", 32'({fe4, brk4}), 32'd0);
      check("reset_active", 32'({act4, act16}), 32'd0);
      i_Reset = 1'b0;
      idle(5);

      // Single frame A5
      send4(8'hA5, 1'b1, e0);
      idle(10);
      check("a5_count", 32'(dv4_byte.size()), 32'd1);
      check("a5_byte", 32'(dv4_byte[0]), 32'hA5);
      check("a5_latency", 32'(dv4_cyc[0] - e0), 32'd38);
      check("a5_no_err", 32'(fe4_n + brk4_n), 32'd0);

      // Back-to-back frames with no idle gap
      send4(8'h00, 1'b1, e0);
      send4(8'hFF, 1'b1, e1);
      send4(8'h55, 1'b1, e2);
      idle(10);
      check("b2b_count", 32'(dv4_byte.size()), 32'd4);
      check("b2b_byte0", 32'(dv4_byte[1]), 32'h00);
      check("b2b_byte1", 32'(dv4_byte[2]), 32'hFF);
      check("b2b_byte2", 32'(dv4_byte[3]), 32'h55);
      check("b2b_lat0", 32'(dv4_cyc[1] - e0), 32'd38);
      check("b2b_gap01", 32'(dv4_cyc[2] - dv4_cyc[1]), 32'd40);
      check("b2b_gap12", 32'(dv4_cyc[3] - dv4_cyc[2]), 32'd40);

      // One-cycle glitch on the CPB=16 line: START for H+1 = 8 cycles, then IDLE
      rx16 = 1'b0;
      idle(1);
      rx16 = 1'b1;
      idle(40);
      check("glitch_no_dv", 32'(dv16_n), 32'd0);
      check("glitch_no_err", 32'(fe16_n), 32'd0);
      check("glitch_active_cycles", 32'(act16_n), 32'd8);
      check("glitch_idle", 32'(act16), 32'd0);

      // Frame 3C with low stop bit
      send4(8'h3C, 1'b0, e0);
      idle(10);
      check("ferr_count", 32'(fe4_n), 32'd1);
      check("ferr_no_break", 32'(brk4_n), 32'd0);
      check("ferr_no_dv", 32'(dv4_byte.size()), 32'd4);
      check("ferr_byte_kept", 32'(byte4), 32'h55);

      // Break: line low for 20 bit times
      fe_base  = fe4_n;
      brk_base = brk4_n;
      rx4 = 1'b0;
      idle(80);
      check("brk_wait_inactive", 32'(act4), 32'd0);
      rx4 = 1'b1;
      idle(10);
      check("brk_ferr", 32'(fe4_n - fe_base), 32'd1);
      check("brk_break", 32'(brk4_n - brk_base), 32'd1);
      check("brk_coincident", 32'(brk4_solo), 32'd0);
      check("brk_no_dv", 32'(dv4_byte.size()), 32'd4);
      send4(8'h81, 1'b1, e0);
      idle(10);
      check("post_brk_count", 32'(dv4_byte.size()), 32'd5);
      check("post_brk_byte", 32'(dv4_byte[4]), 32'h81);
      check("post_brk_lat", 32'(dv4_cyc[4] - e0), 32'd38);

      // Reset during data bit 4 of a frame carrying 8'h0F
      rx4 = 1'b0;
      idle(4);
      for (int i = 0; i < 4; i++) begin
         rx4 = 1'b1;
         idle(4);
      end
      rx4 = 1'b0;
      idle(2);
      i_Reset = 1'b1;
      rx4     = 1'b1;
      #1;
      check("rst_mid_active", 32'(act4), 32'd0);
      check("rst_mid_byte", 32'(byte4), 32'h00);
      check("rst_mid_pulses", 32'({dv4, fe4, brk4}), 32'd0);
      idle(3);
      i_Reset = 1'b0;
      fe_base = fe4_n;
      idle(60);
      check("rst_no_dv", 32'(dv4_byte.size()), 32'd5);
      check("rst_no_err", 32'(fe4_n - fe_base), 32'd0);
      send4(8'h7E, 1'b1, e0);
      idle(10);
      check("post_rst_count", 32'(dv4_byte.size()), 32'd6);
      check("post_rst_byte", 32'(dv4_byte[5]), 32'h7E);
      check("post_rst_out", 32'(byte4), 32'h7E);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
